fifo_rptr_empty: RTL and testbench

Read-side controller of the dual-clock FIFO, running entirely in the rclk domain. It consumes the write pointer already synchronized into rclk, and produces the Gray read pointer sent back to the write domain and the binary read address for the FIFO memory. It also generates the registered empty/almost-empty flags and fill count, and the read data path, with an optional first-word-fall-through (FWFT) output stage. It sits between the write-to-read pointer synchronizer and the consumer logic (spectrogram/fingerprint reader).

---
 rtl/fifo_pkg.sv | 56 +++++
 rtl/fifo_rd_outreg.sv | 66 ++++++
 rtl/fifo_rptr_empty.sv | 124 ++++++++++++
 tb/tb_fifo_rptr_empty.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg
//   Shared definitions for the dual-clock FIFO: default geometry and the
//   Gray/binary pointer conversion helpers used by the read-side and write-side
//   controllers and the pointer synchronizers.
//
//   Contents:
//     FIFO_ASIZE, FIFO_DSIZE  default address width / data word width
//     FIFO_PTR_MAXW           widest pointer the helper functions handle
//     fifo_ptr_t              pointer container type used by the helpers
//     outreg_state_e          occupancy state of the read output register
//     bin2gray(bin, width)    binary -> Gray over the low 'width' bits
//     gray2bin(gray, width)   Gray -> binary over the low 'width' bits
package fifo_pkg;

    localparam int unsigned FIFO_ASIZE    = 4;
    localparam int unsigned FIFO_DSIZE    = 16;
    localparam int unsigned FIFO_PTR_MAXW = 32;

    typedef logic [FIFO_PTR_MAXW-1:0] fifo_ptr_t;

    typedef enum logic {
        OUTREG_EMPTY = 1'b0,
        OUTREG_FULL  = 1'b1
    } outreg_state_e;

    // Bits at or above 'width' are ignored on input and returned as zero.
    function automatic fifo_ptr_t bin2gray(input fifo_ptr_t bin, input int unsigned width);
        fifo_ptr_t masked;
        masked = '0;
        for (int unsigned i = 0; i < FIFO_PTR_MAXW; i++) begin
            if (i < width) begin
                masked[i] = bin[i];
            end
        end
        return masked ^ (masked >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at and above it, walked
    // from the MSB of the 'width'-bit field down to bit 0.
    function automatic fifo_ptr_t gray2bin(input fifo_ptr_t gray, input int unsigned width);
        fifo_ptr_t   bin;
        logic        acc;
        int unsigned idx;
        bin = '0;
        acc = 1'b0;
        for (int unsigned k = 0; k < FIFO_PTR_MAXW; k++) begin
            idx = FIFO_PTR_MAXW - 1 - k;
            if (idx < width) begin
                acc      = acc ^ gray[idx];
                bin[idx] = acc;
            end
        end
        return bin;
    endfunction

endpackage

// File: rtl/fifo_rd_outreg.sv
// fifo_rd_outreg
//   One-word first-word-fall-through output register for the FIFO read side.
//   Holds the FIFO head so it is presented on rdata with rvalid=1 before the
//   consumer asks for it; refills from memory whenever it is empty or being
//   drained, giving one word per cycle with rinc held.
//
//   Ports:
//     rclk         in   read clock
//     rrst_n       in   asynchronous active-low reset
//     rinc         in   consumer pop request (acts only while rvalid=1)
//     mem_empty    in   registered memory-empty flag from the pointer logic
//     mem_rdata    in   memory word at the current read address
//     mem_pop      out  memory word consumed this cycle (advances read pointer)
//     rvalid_next  out  occupancy after this edge (used by the fill count)
//     rdata        out  held head word
//     rvalid       out  register occupied
module fifo_rd_outreg
    import fifo_pkg::*;
#(
    parameter int unsigned DSIZE = FIFO_DSIZE
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic             rinc,
    input  logic             mem_empty,
    input  logic [DSIZE-1:0] mem_rdata,
    output logic             mem_pop,
    output logic             rvalid_next,
    output logic [DSIZE-1:0] rdata,
    output logic             rvalid
);

    outreg_state_e state;
    outreg_state_e state_next;
    logic          take;

    assign take    = rinc & (state == OUTREG_FULL);
    assign mem_pop = ~mem_empty & ((state == OUTREG_EMPTY) | rinc);

    // A refill wins over a drain: popping the head while loading the next
    // word leaves the register occupied.
    always_comb begin
        state_next = state;
        if (mem_pop) begin
            state_next = OUTREG_FULL;
        end else if (take) begin
            state_next = OUTREG_EMPTY;
        end
    end

    assign rvalid_next = (state_next == OUTREG_FULL);
    assign rvalid      = (state == OUTREG_FULL);

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state <= OUTREG_EMPTY;
            rdata <= '0;
        end else begin
            state <= state_next;
            if (mem_pop) begin
                rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: rtl/fifo_rptr_empty.sv
// fifo_rptr_empty
//   Read-side controller of the dual-clock FIFO (rclk domain). Advances the
//   binary/Gray read pointers, compares against the synchronized Gray write
//   pointer to produce registered empty / almost-empty flags and fill count,
//   and drives the read data path.
//
//   Build option: define FIFO_RD_FWFT_EN for the first-word-fall-through
//   output stage (fifo_rd_outreg); otherwise standard 1-cycle-latency reads.
//
//   Ports:
//     rclk        in   read clock
//     rrst_n      in   asynchronous active-low reset
//     rinc        in   read request / pop
//     rq2_wptr    in   Gray write pointer, already synchronized into rclk
//     mem_rdata   in   asynchronous memory read data at raddr
//     raddr       out  binary memory read address
//     rptr        out  registered Gray read pointer to the write domain
//     rdata       out  read data
//     rvalid      out  rdata valid
//     rempty      out  FIFO empty as seen by the consumer
//     raempty     out  almost empty (rcount <= AEMPTY_THRESH)
//     rcount      out  registered fill level (0..2^ASIZE, plus held word in FWFT)
//     runderflow  out  one-cycle pulse on a refused rinc
module fifo_rptr_empty
    import fifo_pkg::*;
#(
    parameter int unsigned ASIZE         = FIFO_ASIZE,
    parameter int unsigned DSIZE         = FIFO_DSIZE,
    parameter int unsigned AEMPTY_THRESH = 2
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic             rinc,
    input  logic [ASIZE:0]   rq2_wptr,
    input  logic [DSIZE-1:0] mem_rdata,
    output logic [ASIZE-1:0] raddr,
    output logic [ASIZE:0]   rptr,
    output logic [DSIZE-1:0] rdata,
    output logic             rvalid,
    output logic             rempty,
    output logic             raempty,
    output logic [ASIZE:0]   rcount,
    output logic             runderflow
);

    localparam int unsigned    PW        = ASIZE + 1;
    localparam logic [ASIZE:0] AE_THRESH = PW'(AEMPTY_THRESH);

    logic [ASIZE:0] rbin;
    logic [ASIZE:0] rbinnext;
    logic [ASIZE:0] rgraynext;
    logic [ASIZE:0] wbin_s;
    logic [ASIZE:0] mem_count_next;
    logic [ASIZE:0] rcount_next;
    logic           mem_empty;
    logic           mem_pop;

    assign rbinnext  = rbin + {{ASIZE{1'b0}}, mem_pop};
    assign rgraynext = PW'(bin2gray(FIFO_PTR_MAXW'(rbinnext), PW));
    assign wbin_s    = PW'(gray2bin(FIFO_PTR_MAXW'(rq2_wptr), PW));

    // Pointers carry one extra lap bit, so a full FIFO differs by exactly
    // 2^ASIZE and the modular subtraction never aliases full to zero.
    assign mem_count_next = wbin_s - rbinnext;

    assign raddr = rbin[ASIZE-1:0];

`ifdef FIFO_RD_FWFT_EN
    logic hold_next;

    fifo_rd_outreg #(
        .DSIZE (DSIZE)
    ) u_outreg (
        .rclk        (rclk),
        .rrst_n      (rrst_n),
        .rinc        (rinc),
        .mem_empty   (mem_empty),
        .mem_rdata   (mem_rdata),
        .mem_pop     (mem_pop),
        .rvalid_next (hold_next),
        .rdata       (rdata),
        .rvalid      (rvalid)
    );

    assign rempty      = ~rvalid;
    // The held head word has already left memory but is still unread.
    assign rcount_next = mem_count_next + {{ASIZE{1'b0}}, hold_next};
`else
    assign mem_pop     = rinc & ~mem_empty;
    assign rempty      = mem_empty;
    assign rcount_next = mem_count_next;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= mem_pop;
            if (mem_pop) begin
                rdata <= mem_rdata;
            end
        end
    end
`endif

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin       <= '0;
            rptr       <= '0;
            mem_empty  <= 1'b1;
            rcount     <= '0;
            raempty    <= 1'b1;
            runderflow <= 1'b0;
        end else begin
            rbin       <= rbinnext;
            rptr       <= rgraynext;
            mem_empty  <= (rgraynext == rq2_wptr);
            rcount     <= rcount_next;
            raempty    <= (rcount_next <= AE_THRESH);
            runderflow <= rinc & rempty;
        end
    end

endmodule

// File: tb/tb_fifo_rptr_empty.sv
`timescale 1ns/1ps
module tb_fifo_rptr_empty;

    localparam int DEPTH = 16;

    logic        rclk = 1'b0;
    logic        rrst_n;
    logic        rinc;
    logic [4:0]  rq2_wptr;
    logic [15:0] mem_rdata;
    logic [3:0]  raddr;
    logic [4:0]  rptr;
    logic [15:0] rdata;
    logic        rvalid;
    logic        rempty;
    logic        raempty;
    logic [4:0]  rcount;
    logic        runderflow;

    fifo_rptr_empty #(
        .ASIZE         (4),
        .DSIZE         (16),
        .AEMPTY_THRESH (2)
    ) dut (
        .rclk       (rclk),
        .rrst_n     (rrst_n),
        .rinc       (rinc),
        .rq2_wptr   (rq2_wptr),
        .mem_rdata  (mem_rdata),
        .raddr      (raddr),
        .rptr       (rptr),
        .rdata      (rdata),
        .rvalid     (rvalid),
        .rempty     (rempty),
        .raempty    (raempty),
        .rcount     (rcount),
        .runderflow (runderflow)
    );

    always #5 rclk = ~rclk;

    logic [15:0] mem [DEPTH];
    assign mem_rdata = mem[raddr];

    int          total = 0;
    int          bad   = 0;
    logic [15:0] sb_q[$];
    logic [15:0] last_data = 16'h0000;
    int unsigned wbin = 0;
    int unsigned exp_rbin = 0;

    function automatic logic [4:0] to_gray(input int unsigned b);
        logic [4:0] v;
        v = 5'(b);
        return v ^ (v >> 1);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Writer model: fills memory, records expected order, publishes pointer.
    task automatic write_words(input int unsigned n);
        logic [15:0] d;
        for (int unsigned i = 0; i < n; i++) begin
            d = 16'($urandom_range(0, 65535));
            mem[wbin % DEPTH] = d;
            sb_q.push_back(d);
            wbin = (wbin + 1) % 32;
        end
        rq2_wptr = to_gray(wbin);
    endtask

    task automatic tick();
        logic [15:0] e;
        @(posedge rclk);
        #1;
`ifndef FIFO_RD_FWFT_EN
        if (rvalid) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_rvalid", int'(rvalid), 0);
            end else begin
                e = sb_q.pop_front();
                chk("rdata", int'(rdata), int'(e));
                last_data = e;
            end
        end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

`ifndef FIFO_RD_FWFT_EN
    typedef struct {
        int unsigned nwr;
        int unsigned npop;
        int unsigned cnt;
        logic        emp;
        logic        ae;
    } vec_t;
    vec_t vecs[11];
`endif

    initial begin
        int seen;
        int n;
        logic [15:0] e;
        for (int i = 0; i < DEPTH; i++) mem[i] = 16'h0000;
        rrst_n   = 1'b0;
        rinc     = 1'b0;
        rq2_wptr = 5'd0;
        #12;
        chk("rst_rptr",    int'(rptr), 0);
        chk("rst_raddr",   int'(raddr), 0);
        chk("rst_rdata",   int'(rdata), 0);
        chk("rst_rvalid",  int'(rvalid), 0);
        chk("rst_rempty",  int'(rempty), 1);
        chk("rst_raempty", int'(raempty), 1);
        chk("rst_rcount",  int'(rcount), 0);
        chk("rst_runderflow", int'(runderflow), 0);
        @(negedge rclk);
        rrst_n = 1'b1;
        tick();

`ifndef FIFO_RD_FWFT_EN
        //          nwr npop cnt  emp   ae
        vecs[0]  = '{ 0,  0,  0, 1'b1, 1'b1};
        vecs[1]  = '{ 3,  0,  3, 1'b0, 1'b0};
        vecs[2]  = '{ 0,  1,  2, 1'b0, 1'b1};
        vecs[3]  = '{ 0,  1,  1, 1'b0, 1'b1};
        vecs[4]  = '{ 0,  1,  0, 1'b1, 1'b1};
        vecs[5]  = '{13,  0, 13, 1'b0, 1'b0};
        vecs[6]  = '{ 3,  0, 16, 1'b0, 1'b0};
        vecs[7]  = '{ 0, 12,  4, 1'b0, 1'b0};
        vecs[8]  = '{ 0,  2,  2, 1'b0, 1'b1};
        vecs[9]  = '{ 0,  2,  0, 1'b1, 1'b1};
        vecs[10] = '{14, 14,  0, 1'b1, 1'b1};

        for (int v = 0; v < 11; v++) begin
            write_words(vecs[v].nwr);
            tick();
            seen = 0;
            for (int unsigned p = 0; p < vecs[v].npop; p++) begin
                chk("raddr", int'(raddr), int'(exp_rbin % DEPTH));
                rinc = 1'b1;
                tick();
                if (rvalid) seen++;
                exp_rbin = (exp_rbin + 1) % 32;
            end
            rinc = 1'b0;
            tick();
            chk("vec_nvalid",  seen, int'(vecs[v].npop));
            chk("vec_rcount",  int'(rcount), int'(vecs[v].cnt));
            chk("vec_rempty",  int'(rempty), int'(vecs[v].emp));
            chk("vec_raempty", int'(raempty), int'(vecs[v].ae));
            chk("vec_rptr",    int'(rptr), int'(to_gray(exp_rbin)));
            chk("vec_runderflow", int'(runderflow), 0);
        end

        // Refused read: only the underflow pulse moves.
        rinc = 1'b1;
        tick();
        chk("uf_pulse",  int'(runderflow), 1);
        chk("uf_rptr",   int'(rptr), int'(to_gray(exp_rbin)));
        chk("uf_rvalid", int'(rvalid), 0);
        chk("uf_rdata",  int'(rdata), int'(last_data));
        rinc = 1'b0;
        tick();
        chk("uf_clear",  int'(runderflow), 0);

        // Empty deasserts one edge after the pointer changes.
        write_words(1);
        #1;
        chk("ed_before", int'(rempty), 1);
        tick();
        chk("ed_after",  int'(rempty), 0);
        chk("ed_rcount", int'(rcount), 1);
        chk("ed_raddr",  int'(raddr), int'(exp_rbin % DEPTH));
        rinc = 1'b1;
        tick();
        exp_rbin = (exp_rbin + 1) % 32;
        chk("ed_rvalid", int'(rvalid), 1);
        chk("ed_empty_again", int'(rempty), 1);
        rinc = 1'b0;
        tick();
        chk("ed_rvalid_drop", int'(rvalid), 0);

        // Asynchronous reset mid-stream.
        write_words(5);
        tick();
        rinc = 1'b1;
        tick();
        rinc = 1'b0;
        #3;
        rrst_n = 1'b0;
        #1;
        chk("mr_rptr",    int'(rptr), 0);
        chk("mr_raddr",   int'(raddr), 0);
        chk("mr_rdata",   int'(rdata), 0);
        chk("mr_rvalid",  int'(rvalid), 0);
        chk("mr_rempty",  int'(rempty), 1);
        chk("mr_raempty", int'(raempty), 1);
        chk("mr_rcount",  int'(rcount), 0);
        wbin = 0;
        exp_rbin = 0;
        rq2_wptr = 5'd0;
        sb_q.delete();
        @(negedge rclk);
        rrst_n = 1'b1;
        tick();
        chk("mr_post_empty", int'(rempty), 1);

        // Three words with rinc held from the moment they become visible.
        write_words(3);
        rinc = 1'b1;
        tick();
        chk("b2b_rempty", int'(rempty), 0);
        chk("b2b_uf",     int'(runderflow), 1);
        chk("b2b_rvalid0", int'(rvalid), 0);
        for (int k = 0; k < 3; k++) begin
            chk("b2b_raddr", int'(raddr), k);
            tick();
            chk("b2b_rvalid", int'(rvalid), 1);
        end
        tick();
        chk("b2b_rvalid_end", int'(rvalid), 0);
        chk("b2b_rempty_end", int'(rempty), 1);
        chk("b2b_rptr", int'(rptr), 2);
        rinc = 1'b0;
        tick();
`else
        // FWFT: a single word falls through without a request.
        mem[0] = 16'hBEEF;
        sb_q.push_back(16'hBEEF);
        wbin = 1;
        rq2_wptr = to_gray(wbin);
        tick();
        tick();
        e = sb_q.pop_front();
        chk("fw_rvalid", int'(rvalid), 1);
        chk("fw_rdata",  int'(rdata), int'(e));
        chk("fw_rempty", int'(rempty), 0);
        chk("fw_rcount", int'(rcount), 1);
        chk("fw_rptr",   int'(rptr), 1);
        rinc = 1'b1;
        tick();
        chk("fw_pop_rvalid",  int'(rvalid), 0);
        chk("fw_pop_rempty",  int'(rempty), 1);
        chk("fw_pop_rcount",  int'(rcount), 0);
        chk("fw_pop_raempty", int'(raempty), 1);
        tick();
        chk("fw_uf_pulse", int'(runderflow), 1);
        rinc = 1'b0;
        tick();
        chk("fw_uf_clear", int'(runderflow), 0);

        // Sustained draining with rinc held.
        write_words(4);
        tick();
        tick();
        chk("fw_s_rcount", int'(rcount), 4);
        rinc = 1'b1;
        n = 0;
        for (int k = 0; k < 8; k++) begin
            if (rvalid) begin
                e = sb_q.pop_front();
                chk("fw_s_rdata", int'(rdata), int'(e));
                n++;
            end
            tick();
        end
        rinc = 1'b0;
        chk("fw_s_count", n, 4);
        chk("fw_s_rcount_end", int'(rcount), 0);
        chk("fw_s_rempty_end", int'(rempty), 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
